dmem_access_sequencer: RTL and testbench

// - Sequences every core load/store onto the data-memory bus using a req/gnt + rvalid handshake.
// - Sits between the core's load/store decode (addr/size/signedness) and the dmem port.
// - Builds byte strobes and lane-shifted write data, detects misaligned accesses, times out hung responses.
// - Returns sign/zero-extended load data with a 2-bit status. Exactly one transaction is outstanding at a time.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/dmem_load_extend.sv | 27 ++
 rtl/dmem_access_sequencer.sv | 170 +++++++++++++++++
 tb/tb_dmem_access_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store types: access sizes, response status codes and sequencer states.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned XBYTES = XLEN / 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_BUS      = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } lsu_err_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    ERR_RSP  = 2'd3
  } dseq_state_e;

  // Half needs addr[0]=0, word needs addr[1:0]=0; size encoding 3 is never legal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Pulls the addressed byte/half out of a raw bus word and sign- or zero-extends it.
module dmem_load_extend
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  mem_size_e       size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] ext_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension; word loads pass straight through.
  always_comb begin
    byte_sel   = rdata[{offset, 3'b000} +: 8];
    half_sel   = rdata[{offset[1], 4'b0000} +: 16];
    ext_data_c = rdata;
    case (size)
      SZ_B:    ext_data_c = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    ext_data_c = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ext_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_sequencer.sv
// Sequences single outstanding core loads/stores onto a req/gnt + rvalid data-memory bus.
module dmem_access_sequencer
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_err,
  output logic                    mem_req,
  input  logic                    mem_gnt,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_err,
  output logic                    busy
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  dseq_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  mem_size_e             size_q;
  logic                  uns_q;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  accept;
  logic [DATA_WIDTH-1:0] load_data_c;
  lsu_err_e              err_c;

  assign accept    = req_valid && (state_q == IDLE);
  assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign rsp_err   = err_c;

  // Byte strobes and lane-shifted store data; loads read the full word.
  always_comb begin
    be_d    = '1;
    wdata_d = '0;
    if (req_write) begin
      case (req_size)
        2'd0: begin
          be_d    = BE_W'(4'b0001) << req_addr[1:0];
          wdata_d = req_wdata << {req_addr[1:0], 3'b000};
        end
        2'd1: begin
          be_d    = BE_W'(4'b0011) << {req_addr[1], 1'b0};
          wdata_d = req_wdata << {req_addr[1], 4'b0000};
        end
        default: begin
          be_d    = '1;
          wdata_d = req_wdata;
        end
      endcase
    end
  end

  // Request capture on accept; held stable for the whole bus transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      we_q    <= req_write;
      size_q  <= mem_size_e'(req_size);
      uns_q   <= req_unsigned;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  // Response-wait counter: cleared while requesting, counts each WAIT_RSP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == REQ) begin
      cnt_q <= '0;
    end else if (state_q == WAIT_RSP) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  dmem_load_extend u_load_extend (
    .rdata       (mem_rdata),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext_data_c  (load_data_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; the response is combinational off mem_rvalid.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    err_c     = ERR_NONE;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = is_misaligned(req_size, req_addr[1:0]) ? ERR_RSP : REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid) begin
          rsp_valid = 1'b1;
          state_d   = IDLE;
          if (mem_err) begin
            err_c = ERR_BUS;
          end else if (!we_q) begin
            rsp_rdata = load_data_c;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rsp_valid = 1'b1;
          err_c     = ERR_TIMEOUT;
          state_d   = IDLE;
        end
      end
      ERR_RSP: begin
        rsp_valid = 1'b1;
        err_c     = ERR_MISALIGN;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_sequencer.sv
// Directed bench for dmem_access_sequencer with a short response timeout.
module tb_dmem_access_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [1:0]  mis_sz   [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
  logic [31:0] mis_addr [4] = '{32'h3001, 32'h3003, 32'h3000, 32'h3002};
  logic        mis_wr   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  dmem_access_sequencer #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .mem_err      (mem_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access: accept, immediate grant, response on the following cycle.
  task automatic run_txn(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input logic merr, input logic [3:0] ebe, input logic [31:0] ewd,
                         input logic [31:0] erd, input logic [1:0] eerr);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0; mem_gnt = 1'b1;
    #1;
    chk({tag, ".mem_req"}, 32'(mem_req), 32'd1);
    chk({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, ".mem_be"}, 32'(mem_be), 32'(ebe));
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(w));
    if (w) chk({tag, ".mem_wdata"}, mem_wdata, ewd);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd; mem_err = merr;
    #1;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(eerr));
    chk({tag, ".rsp_rdata"}, rsp_rdata, erd);
    tick();
    mem_rvalid = 1'b0; mem_err = 1'b0;
    #1;
    chk({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".ready_next"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.mem_be", 32'(mem_be), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst.ready", 32'(req_ready), 32'd1);

    // Stores: lane strobes and shifted data
    run_txn("sb3", 1'b1, 2'd0, 1'b0, 32'h1003, 32'h000000A5, 32'hDEADBEEF, 1'b0,
            4'b1000, 32'hA5000000, 32'h0, 2'd0);
    run_txn("sb1", 1'b1, 2'd0, 1'b0, 32'h1001, 32'hFFFFFF5A, 32'h0, 1'b0,
            4'b0010, 32'hFFFF5A00, 32'h0, 2'd0);
    run_txn("sh2", 1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234ABCD, 32'h0, 1'b0,
            4'b1100, 32'hABCD0000, 32'h0, 2'd0);
    run_txn("sw", 1'b1, 2'd2, 1'b0, 32'h4000, 32'h11223344, 32'h0, 1'b0,
            4'b1111, 32'h11223344, 32'h0, 2'd0);

    // Loads: extraction and extension
    run_txn("lh2s", 1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h80011234, 1'b0,
            4'b1111, 32'h0, 32'hFFFF8001, 2'd0);
    run_txn("lh2u", 1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h80011234, 1'b0,
            4'b1111, 32'h0, 32'h00008001, 2'd0);
    run_txn("lh0s", 1'b0, 2'd1, 1'b0, 32'h2000, 32'h0, 32'h80011234, 1'b0,
            4'b1111, 32'h0, 32'h00001234, 2'd0);
    run_txn("lb3s", 1'b0, 2'd0, 1'b0, 32'h2003, 32'h0, 32'h80011234, 1'b0,
            4'b1111, 32'h0, 32'hFFFFFF80, 2'd0);
    run_txn("lb1u", 1'b0, 2'd0, 1'b1, 32'h2001, 32'h0, 32'h80011234, 1'b0,
            4'b1111, 32'h0, 32'h00000012, 2'd0);
    run_txn("lw", 1'b0, 2'd2, 1'b0, 32'h4004, 32'h0, 32'hCAFEF00D, 1'b0,
            4'b1111, 32'h0, 32'hCAFEF00D, 2'd0);
    run_txn("lwerr", 1'b0, 2'd2, 1'b0, 32'h4008, 32'h0, 32'h12345678, 1'b1,
            4'b1111, 32'h0, 32'h0, 2'd2);

    // Misaligned / illegal size: response next cycle, no bus request
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_write = mis_wr[i]; req_size = mis_sz[i]; req_unsigned = 1'b0;
      req_addr = mis_addr[i]; req_wdata = 32'h55AA55AA;
      #1;
      chk("mis.ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      #1;
      chk("mis.rsp_valid", 32'(rsp_valid), 32'd1);
      chk("mis.rsp_err", 32'(rsp_err), 32'd1);
      chk("mis.rsp_rdata", rsp_rdata, 32'h0);
      chk("mis.mem_req", 32'(mem_req), 32'd0);
      tick();
      chk("mis.rsp_done", 32'(rsp_valid), 32'd0);
      chk("mis.mem_req_after", 32'(mem_req), 32'd0);
      chk("mis.ready_next", 32'(req_ready), 32'd1);
    end

    // Grant withheld 5 cycles, stray rvalid in REQ, then bus error
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h5006; req_wdata = 32'h0000BEEF;
    #1;
    tick();
    req_valid = 1'b0; req_addr = 32'hFFFFFFFF; req_wdata = 32'h12345678; req_size = 2'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold.mem_req", 32'(mem_req), 32'd1);
      chk("hold.mem_addr", mem_addr, 32'h5004);
      chk("hold.mem_be", 32'(mem_be), 32'hC);
      chk("hold.mem_wdata", mem_wdata, 32'hBEEF0000);
      chk("hold.rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
    end
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    #1;
    chk("hold6.mem_req", 32'(mem_req), 32'd1);
    chk("hold6.mem_addr", mem_addr, 32'h5004);
    chk("hold6.mem_be", 32'(mem_be), 32'hC);
    chk("hold6.mem_wdata", mem_wdata, 32'hBEEF0000);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_err = 1'b1;
    #1;
    chk("buserr.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("buserr.rsp_err", 32'(rsp_err), 32'd2);
    chk("buserr.rsp_rdata", rsp_rdata, 32'h0);
    tick();
    mem_rvalid = 1'b0; mem_err = 1'b0;
    #1;
    chk("buserr.done", 32'(rsp_valid), 32'd0);

    // Timeout on the 4th WAIT_RSP cycle, then a late response is ignored
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h6000;
    #1;
    tick();
    req_valid = 1'b0; mem_gnt = 1'b1;
    #1;
    chk("to.mem_req", 32'(mem_req), 32'd1);
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("to.wait_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("to.wait_busy", 32'(busy), 32'd1);
      tick();
    end
    #1;
    chk("to.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to.rsp_err", 32'(rsp_err), 32'd3);
    chk("to.rsp_rdata", rsp_rdata, 32'h0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h00000055;
    #1;
    chk("late.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("late.busy", 32'(busy), 32'd0);
    chk("late.ready", 32'(req_ready), 32'd1);
    tick();
    mem_rvalid = 1'b0;

    // Response arriving in the expiry cycle wins over the timeout
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd1; req_unsigned = 1'b1; req_addr = 32'h6002;
    #1;
    tick();
    req_valid = 1'b0; mem_gnt = 1'b1;
    #1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("exp.wait_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A51111;
    #1;
    chk("exp.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("exp.rsp_err", 32'(rsp_err), 32'd0);
    chk("exp.rsp_rdata", rsp_rdata, 32'h0000A5A5);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("exp.done", 32'(rsp_valid), 32'd0);

    // Reset pulse while waiting for a response aborts the access
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h7000;
    #1;
    tick();
    req_valid = 1'b0; mem_gnt = 1'b1;
    #1;
    tick();
    mem_gnt = 1'b0;
    #1;
    chk("abort.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort.mem_req", 32'(mem_req), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    #1;
    chk("abort.rel_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort.rel_busy", 32'(busy), 32'd0);
    chk("abort.rel_ready", 32'(req_ready), 32'd1);
    chk("abort.rel_mem_req", 32'(mem_req), 32'd0);
    tick();
    mem_rvalid = 1'b0;

    run_txn("post", 1'b0, 2'd0, 1'b0, 32'h7004, 32'h0, 32'h0000007F, 1'b0,
            4'b1111, 32'h0, 32'h0000007F, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
